// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between instruction fetch (imem) and
//   data access (dmem). One transaction is outstanding at a time; the owner
//   of that transaction is latched so the response goes back to it. dmem has
//   fixed priority, limited by a starvation guard so a waiting imem is
//   served after at most p_starve_max consecutive dmem grants.
//
//   Ports
//     clk, rst                      clock, synchronous active-high reset
//     imemreq_val/rdy/addr          fetch request
//     imemresp_val/data             fetch response
//     dmemreq_val/rdy/type/addr/wdata  data request (type 1 = write)
//     dmemresp_val/data             data response (also pulses for writes)
//     memreq_val/rdy/type/addr/wdata   request to memory
//     memresp_val/data              memory response
//     err                           sticky: response arrived with nothing outstanding
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no transaction outstanding; grant and forward a request
//   BUSY  | one transaction outstanding; waiting for memresp_val

module mem_port_arbiter #(
  parameter int unsigned p_starve_max = 3
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        imemreq_val,
  output logic        imemreq_rdy,
  input  logic [31:0] imemreq_addr,
  output logic        imemresp_val,
  output logic [31:0] imemresp_data,

  input  logic        dmemreq_val,
  output logic        dmemreq_rdy,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic        dmemresp_val,
  output logic [31:0] dmemresp_data,

  output logic        memreq_val,
  input  logic        memreq_rdy,
  output logic        memreq_type,
  output logic [31:0] memreq_addr,
  output logic [31:0] memreq_wdata,
  input  logic        memresp_val,
  input  logic [31:0] memresp_data,

  output logic        err
);

  localparam logic [3:0] STARVE_MAX = 4'(p_starve_max);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_IMEM, OWN_DMEM} owner_t;

  state_t     state, state_nxt;
  owner_t     owner, owner_nxt;
  logic [3:0] streak, streak_nxt;
  logic       err_q, err_nxt;

  logic starve, grant_d, grant_i, fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= OWN_IMEM;
      streak <= 4'd0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      streak <= streak_nxt;
      err_q  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    streak_nxt    = streak;
    err_nxt       = err_q;

    memreq_val    = 1'b0;
    memreq_type   = 1'b0;
    memreq_addr   = 32'd0;
    memreq_wdata  = 32'd0;
    imemreq_rdy   = 1'b0;
    dmemreq_rdy   = 1'b0;
    imemresp_val  = 1'b0;
    imemresp_data = 32'd0;
    dmemresp_val  = 1'b0;
    dmemresp_data = 32'd0;

    starve  = imemreq_val & (streak == STARVE_MAX);
    grant_d = dmemreq_val & ~starve;
    grant_i = imemreq_val & ~grant_d;
    fire    = 1'b0;

    // All outputs held at zero during reset; next-state values are
    // irrelevant then because the register reset takes priority.
    if (!rst) begin
      case (state)
        IDLE: begin
          memreq_val  = grant_d | grant_i;
          if (grant_d) begin
            memreq_type  = dmemreq_type;
            memreq_addr  = dmemreq_addr;
            memreq_wdata = dmemreq_wdata;
          end else if (grant_i) begin
            memreq_addr  = imemreq_addr;
          end
          imemreq_rdy = grant_i & memreq_rdy;
          dmemreq_rdy = grant_d & memreq_rdy;
          fire        = memreq_val & memreq_rdy;

          if (fire) begin
            state_nxt = BUSY;
            owner_nxt = grant_d ? OWN_DMEM : OWN_IMEM;
            if (grant_d && imemreq_val)
              streak_nxt = (streak >= STARVE_MAX) ? STARVE_MAX : streak + 4'd1;
            else
              streak_nxt = 4'd0;
          end

          // Nothing is outstanding, so a response here is a protocol error.
          if (memresp_val)
            err_nxt = 1'b1;
        end

        BUSY: begin
          if (memresp_val) begin
            state_nxt = IDLE;
            if (owner == OWN_DMEM) begin
              dmemresp_val  = 1'b1;
              dmemresp_data = memresp_data;
            end else begin
              imemresp_val  = 1'b1;
              imemresp_data = memresp_data;
            end
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  assign err = err_q & ~rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int P = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imemreq_val = 1'b0;
  logic        imemreq_rdy;
  logic [31:0] imemreq_addr = 32'd0;
  logic        imemresp_val;
  logic [31:0] imemresp_data;
  logic        dmemreq_val = 1'b0;
  logic        dmemreq_rdy;
  logic        dmemreq_type = 1'b0;
  logic [31:0] dmemreq_addr = 32'd0;
  logic [31:0] dmemreq_wdata = 32'd0;
  logic        dmemresp_val;
  logic [31:0] dmemresp_data;
  logic        memreq_val;
  logic        memreq_rdy = 1'b0;
  logic        memreq_type;
  logic [31:0] memreq_addr;
  logic [31:0] memreq_wdata;
  logic        memresp_val = 1'b0;
  logic [31:0] memresp_data = 32'd0;
  logic        err;

  mem_port_arbiter #(.p_starve_max(P)) dut (
    .clk(clk), .rst(rst),
    .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy), .imemreq_addr(imemreq_addr),
    .imemresp_val(imemresp_val), .imemresp_data(imemresp_data),
    .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy), .dmemreq_type(dmemreq_type),
    .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata),
    .dmemresp_val(dmemresp_val), .dmemresp_data(dmemresp_data),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
    .memreq_addr(memreq_addr), .memreq_wdata(memreq_wdata),
    .memresp_val(memresp_val), .memresp_data(memresp_data),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Memory stand-in: answers each accepted request after a latency of
  // 1..3 cycles (or a fixed one), and can inject a spurious response.
  bit          fire_flag = 0;
  int          pend = 0;
  int          fix_lat = 0;
  bit          use_fix = 0;
  logic [31:0] fix_data = 32'd0;
  bit          force_resp = 0;

  always @(posedge clk) begin
    #2;
    memresp_val = 1'b0;
    if (rst) begin
      pend = 0;
    end else begin
      if (fire_flag) pend = (fix_lat != 0) ? fix_lat : int'($urandom_range(1, 3));
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          memresp_val  = 1'b1;
          memresp_data = use_fix ? fix_data : $urandom;
        end
      end
    end
    fire_flag = 0;
    if (force_resp) begin
      memresp_val  = 1'b1;
      memresp_data = $urandom;
    end
  end

  // Reference model: one outstanding transaction, a remembered owner, a
  // count of dmem wins taken while imem was waiting, and a sticky error.
  bit    m_busy = 0;
  bit    m_own_d = 0;
  bit    m_own_wr = 0;
  int    m_run = 0;
  bit    m_err = 0;
  string glog = "";

  always @(negedge clk) begin
    logic        e_mv, e_mt, e_ir, e_dr, e_iv, e_dv, d_wins;
    logic [31:0] e_ma, e_mw;
    e_mv = 0; e_mt = 0; e_ir = 0; e_dr = 0; e_iv = 0; e_dv = 0;
    e_ma = 0; e_mw = 0; d_wins = 0;

    if (!rst && !m_busy) begin
      d_wins = dmemreq_val && !(imemreq_val && m_run >= P);
      e_mv   = dmemreq_val || imemreq_val;
      if (d_wins) begin
        e_mt = dmemreq_type; e_ma = dmemreq_addr; e_mw = dmemreq_wdata;
      end else if (imemreq_val) begin
        e_ma = imemreq_addr;
      end
      e_ir = imemreq_val && !d_wins && memreq_rdy;
      e_dr = d_wins && memreq_rdy;
    end else if (!rst && m_busy && memresp_val) begin
      e_dv = m_own_d;
      e_iv = !m_own_d;
    end

    chk1 ("m_memreq_val",   memreq_val,   e_mv);
    chk1 ("m_memreq_type",  memreq_type,  e_mt);
    chk32("m_memreq_addr",  memreq_addr,  e_ma);
    chk32("m_memreq_wdata", memreq_wdata, e_mw);
    chk1 ("m_imemreq_rdy",  imemreq_rdy,  e_ir);
    chk1 ("m_dmemreq_rdy",  dmemreq_rdy,  e_dr);
    chk1 ("m_imemresp_val", imemresp_val, e_iv);
    chk1 ("m_dmemresp_val", dmemresp_val, e_dv);
    chk1 ("m_err",          err,          rst ? 1'b0 : m_err);
    if (e_iv) chk32("m_imemresp_data", imemresp_data, memresp_data);
    if (e_dv && !m_own_wr) chk32("m_dmemresp_data", dmemresp_data, memresp_data);

    fire_flag = memreq_val && memreq_rdy;
    if (imemreq_rdy) glog = {glog, "I"};
    if (dmemreq_rdy) glog = {glog, "D"};

    if (rst) begin
      m_busy = 0; m_own_d = 0; m_own_wr = 0; m_run = 0; m_err = 0;
    end else if (!m_busy) begin
      if (e_mv && memreq_rdy) begin
        m_busy   = 1;
        m_own_d  = d_wins;
        m_own_wr = d_wins && dmemreq_type;
        if (d_wins && imemreq_val) m_run = (m_run + 1 > P) ? P : m_run + 1;
        else                       m_run = 0;
      end
      if (memresp_val) m_err = 1;
    end else if (memresp_val) begin
      m_busy = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    imemreq_val = 0; dmemreq_val = 0; dmemreq_type = 0;
    imemreq_addr = 0; dmemreq_addr = 0; dmemreq_wdata = 0;
  endtask

  task automatic drain();
    idle_inputs();
    memreq_rdy = 1;
    repeat (5) cyc();
  endtask

  initial begin
    // Reset: requests and ready present, yet everything must stay low.
    rst = 1; imemreq_val = 1; imemreq_addr = 32'h40; memreq_rdy = 1;
    #1;
    repeat (3) cyc();
    settle();
    chk1("rst_memreq_val", memreq_val, 1'b0);
    chk1("rst_imemreq_rdy", imemreq_rdy, 1'b0);
    chk1("rst_err", err, 1'b0);
    cyc();
    rst = 0;
    drain();

    // Single imem read, 2-cycle memory.
    fix_lat = 2; use_fix = 1; fix_data = 32'h00500093;
    imemreq_val = 1; imemreq_addr = 32'h200; memreq_rdy = 1;
    settle();
    chk1 ("ird_rdy_c0", imemreq_rdy, 1'b1);
    chk32("ird_addr_c0", memreq_addr, 32'h200);
    cyc(); imemreq_val = 0; settle();
    chk1 ("ird_resp_c1", imemresp_val, 1'b0);
    cyc(); settle();
    chk1 ("ird_resp_c2", imemresp_val, 1'b1);
    chk32("ird_data_c2", imemresp_data, 32'h00500093);
    chk1 ("ird_dresp_c2", dmemresp_val, 1'b0);
    drain();

    // Simultaneous requests: dmem write goes first.
    fix_lat = 1;
    imemreq_val = 1; imemreq_addr = 32'h204;
    dmemreq_val = 1; dmemreq_type = 1; dmemreq_addr = 32'h1000; dmemreq_wdata = 32'hCAFE;
    settle();
    chk1 ("sim_type_c0", memreq_type, 1'b1);
    chk32("sim_addr_c0", memreq_addr, 32'h1000);
    chk32("sim_wdata_c0", memreq_wdata, 32'hCAFE);
    chk1 ("sim_drdy_c0", dmemreq_rdy, 1'b1);
    chk1 ("sim_irdy_c0", imemreq_rdy, 1'b0);
    cyc(); dmemreq_val = 0; settle();
    chk1 ("sim_dresp_c1", dmemresp_val, 1'b1);
    chk1 ("sim_irdy_c1", imemreq_rdy, 1'b0);
    cyc(); settle();
    chk1 ("sim_irdy_c2", imemreq_rdy, 1'b1);
    drain();

    // Back-pressure, with dmem arriving mid-stall.
    memreq_rdy = 0; imemreq_val = 1; imemreq_addr = 32'h300;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin
        dmemreq_val = 1; dmemreq_type = 0; dmemreq_addr = 32'h2000;
      end
      settle();
      chk1 ("bp_memreq_val", memreq_val, 1'b1);
      chk1 ("bp_irdy", imemreq_rdy, 1'b0);
      chk32("bp_addr", memreq_addr, (c < 2) ? 32'h300 : 32'h2000);
      cyc();
    end
    memreq_rdy = 1; settle();
    chk1("bp_drdy_accept", dmemreq_rdy, 1'b1);
    chk1("bp_irdy_accept", imemreq_rdy, 1'b0);
    cyc();
    drain();

    // Spurious response while idle.
    force_resp = 1; settle();
    chk1("spur_iresp", imemresp_val, 1'b0);
    chk1("spur_dresp", dmemresp_val, 1'b0);
    chk1("spur_err_c0", err, 1'b0);
    cyc(); force_resp = 0; settle();
    chk1("spur_err_c1", err, 1'b1);
    repeat (3) cyc();
    settle();
    chk1("spur_err_sticky", err, 1'b1);
    cyc(); rst = 1; settle();
    chk1("spur_err_in_rst", err, 1'b0);
    cyc(); rst = 0; settle();
    chk1("spur_err_cleared", err, 1'b0);
    drain();

    // Starvation guard: both held valid, 1-cycle memory.
    rst = 1; cyc(); rst = 0;
    fix_lat = 1;
    imemreq_val = 1; imemreq_addr = 32'h400;
    dmemreq_val = 1; dmemreq_type = 0; dmemreq_addr = 32'h3000;
    glog = "";
    repeat (16) cyc();
    n_checks++;
    if (glog != "DDDIDDDI") begin
      n_errors++;
      $display("FAIL starve_order: got %s expected DDDIDDDI", glog);
    end
    drain();

    // Reset while BUSY, then immediate new request.
    fix_lat = 3;
    imemreq_val = 1; imemreq_addr = 32'h500;
    cyc();
    imemreq_val = 0; rst = 1; settle();
    chk1("rmid_memreq_val", memreq_val, 1'b0);
    chk1("rmid_iresp", imemresp_val, 1'b0);
    chk1("rmid_dresp", dmemresp_val, 1'b0);
    cyc();
    rst = 0; imemreq_val = 1; imemreq_addr = 32'h504; settle();
    chk1("rmid_irdy_after", imemreq_rdy, 1'b1);
    cyc();
    drain();
    settle();
    chk1("rmid_no_err", err, 1'b0);
    cyc();

    // Randomized traffic against the model.
    fix_lat = 0; use_fix = 0;
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 199) == 0);
      imemreq_val   = ($urandom_range(0, 9) < 7);
      imemreq_addr  = $urandom;
      dmemreq_val   = ($urandom_range(0, 9) < 7);
      dmemreq_type  = 1'($urandom_range(0, 1));
      dmemreq_addr  = $urandom;
      dmemreq_wdata = $urandom;
      memreq_rdy    = ($urandom_range(0, 3) != 0);
      cyc();
    end
    rst = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
